// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART ALU bridge: byte width, opcodes (MIPS funct codes) and FSM states.
package uart_defs;

   localparam int DBIT_DEF = 8;

   localparam logic [7:0] OP_ADD = 8'h20;
   localparam logic [7:0] OP_SUB = 8'h22;
   localparam logic [7:0] OP_AND = 8'h24;
   localparam logic [7:0] OP_OR  = 8'h25;
   localparam logic [7:0] OP_XOR = 8'h26;
   localparam logic [7:0] OP_NOR = 8'h27;
   localparam logic [7:0] OP_SRL = 8'h02;
   localparam logic [7:0] OP_SRA = 8'h03;

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      CALC,
      SEND,
      WAIT_TX
   } state_t;

endpackage

// File: rtl/uart_alu_interface_alu.sv
// alu_8: purely combinational ALU for the UART bridge; flags unknown opcodes and returns zero for them.
module alu_8
   import uart_defs::*;
#(
   parameter int DBIT = DBIT_DEF
) (
   input  logic [DBIT-1:0] i_a,
   input  logic [DBIT-1:0] i_b,
   input  logic [DBIT-1:0] i_op,
   output logic [DBIT-1:0] o_result,
   output logic            o_invalid
);

   localparam logic [DBIT-1:0] SHIFT_LIM = DBIT'(DBIT);

   logic w_big_shift;
   assign w_big_shift = (i_b >= SHIFT_LIM);

   always_comb begin
      o_result  = '0;
      o_invalid = 1'b0;
      case (i_op)
         DBIT'(OP_ADD): o_result = i_a + i_b;
         DBIT'(OP_SUB): o_result = i_a - i_b;
         DBIT'(OP_AND): o_result = i_a & i_b;
         DBIT'(OP_OR):  o_result = i_a | i_b;
         DBIT'(OP_XOR): o_result = i_a ^ i_b;
         DBIT'(OP_NOR): o_result = ~(i_a | i_b);
         // Oversized shift amounts saturate explicitly rather than relying on operator semantics.
         DBIT'(OP_SRL): o_result = w_big_shift ? '0 : (i_a >> i_b);
         DBIT'(OP_SRA): o_result = w_big_shift ? {DBIT{i_a[DBIT-1]}}
                                               : DBIT'($signed(i_a) >>> i_b);
         default:       o_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART receiver, computes an ALU result and sends it to the transmitter.
// Optional inter-byte timeout enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_interface
   import uart_defs::*;
#(
   parameter int DBIT           = DBIT_DEF,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rx_done_tick,
   input  logic [DBIT-1:0] rx_data,
   input  logic            tx_done_tick,
   output logic            tx_start,
   output logic [DBIT-1:0] tx_data,
   output logic            busy,
   output logic            frame_err
);

   state_t          r_state;
   state_t          w_state_next;
   logic [DBIT-1:0] r_a;
   logic [DBIT-1:0] r_b;
   logic [DBIT-1:0] r_op;
   logic [DBIT-1:0] r_tx_data;
   logic [DBIT-1:0] w_result;
   logic            w_invalid;
   logic            w_timeout;
   logic            w_collecting;

   assign w_collecting = (r_state == WAIT_B) || (r_state == WAIT_OP);

   alu_8 #(.DBIT(DBIT)) u_alu (
      .i_a       (r_a),
      .i_b       (r_b),
      .i_op      (r_op),
      .o_result  (w_result),
      .o_invalid (w_invalid)
   );

`ifdef UART_IF_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] r_tmo_cnt;

   // A byte arriving on the last allowed cycle wins over the timeout.
   assign w_timeout = w_collecting && !rx_done_tick
                      && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (rx_done_tick || !w_collecting || w_timeout) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WAIT_A:  if (rx_done_tick) w_state_next = WAIT_B;
         WAIT_B: begin
            if (rx_done_tick)   w_state_next = WAIT_OP;
            else if (w_timeout) w_state_next = WAIT_A;
         end
         WAIT_OP: begin
            if (rx_done_tick)   w_state_next = CALC;
            else if (w_timeout) w_state_next = WAIT_A;
         end
         CALC:    w_state_next = SEND;
         SEND:    w_state_next = WAIT_TX;
         WAIT_TX: if (tx_done_tick) w_state_next = WAIT_A;
         default: w_state_next = WAIT_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= WAIT_A;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= '0;
         r_tx_data <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == WAIT_A && rx_done_tick)  r_a  <= rx_data;
         if (r_state == WAIT_B && rx_done_tick)  r_b  <= rx_data;
         if (r_state == WAIT_OP && rx_done_tick) r_op <= rx_data;
         if (r_state == CALC)                    r_tx_data <= w_result;
      end
   end

   // Pulses are gated by reset so a reset landing in SEND or CALC produces neither.
   assign tx_start  = (r_state == SEND) && !reset;
   assign frame_err = (((r_state == CALC) && w_invalid) || w_timeout) && !reset;
   assign busy      = (r_state == CALC) || (r_state == SEND) || (r_state == WAIT_TX);
   assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Scoreboard bench for uart_alu_interface: driver pushes expected bytes, negedge monitor pops and compares.
module tb_uart_alu_interface;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_done_tick = 1'b0;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       busy;
   logic       frame_err;

   typedef struct {
      logic [7:0] data;
      int         err;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cycle = 0;
   int   start_count = 0;
   int   err_in_frame = 0;
   int   timeout_seen = 0;
   int   exp_timeouts = 0;

   uart_alu_interface #(.DBIT(8), .TIMEOUT_CYCLES(100)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .tx_done_tick (tx_done_tick),
      .tx_start     (tx_start),
      .tx_data      (tx_data),
      .busy         (busy),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end else begin
         $display("ok   %s: %0h (cycle %0d)", name, act, cycle);
      end
   endtask

   // Monitor: frame errors while busy belong to the current frame; while idle they are timeouts.
   always @(negedge clk) begin
      exp_t e;
      if (frame_err) begin
         if (busy) err_in_frame++;
         else      timeout_seen++;
      end
      if (tx_start) begin
         start_count++;
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_tx_start: got tx_data %0h with no frame pending (cycle %0d)",
                     tx_data, cycle);
         end else begin
            e = sb.pop_front();
            check("tx_data", tx_data, e.data);
            check("tx_start_latency", cycle, e.cyc);
            check("frame_err_pulses", err_in_frame, e.err);
         end
         err_in_frame = 0;
      end
   end

   task automatic tick_byte(input logic [7:0] b);
      rx_data      = b;
      rx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      rx_done_tick = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                            input logic [7:0] exp, input int err, input bit extra_rx,
                            input int gap_ab);
      int s0;
      tick_byte(a);
      repeat (gap_ab) begin
         @(posedge clk);
         #1;
      end
      tick_byte(b);
      s0 = start_count;
      sb.push_back('{exp, err, cycle + 2});
      tick_byte(op);
      for (int i = 0; i < 20 && start_count == s0; i++) @(posedge clk);
      #1;
      check("tx_start_seen", start_count, s0 + 1);
      if (extra_rx) tick_byte(8'hAA);
      repeat (3) @(posedge clk);
      #1;
      check("tx_data_held", tx_data, exp);
      check("busy_wait_tx", busy, 1'b1);
      tx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      tx_done_tick = 1'b0;
      @(negedge clk);
      check("busy_after_done", busy, 1'b0);
      check("single_tx_start", start_count, s0 + 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_tx_start", tx_start, 1'b0);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_frame_err", frame_err, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Stray tx_done while idle must be ignored.
      tx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      tx_done_tick = 1'b0;

      run_frame(8'h05, 8'h03, 8'h20, 8'h08, 0, 1'b0, 0);
      run_frame(8'hF0, 8'h20, 8'h20, 8'h10, 0, 1'b0, 0);
      run_frame(8'h90, 8'h02, 8'h03, 8'hE4, 0, 1'b0, 0);
      run_frame(8'h90, 8'h09, 8'h02, 8'h00, 0, 1'b0, 0);
      run_frame(8'h90, 8'h09, 8'h03, 8'hFF, 0, 1'b0, 0);
      run_frame(8'h03, 8'h05, 8'h22, 8'hFE, 0, 1'b0, 0);
      run_frame(8'hC3, 8'h5A, 8'h24, 8'h42, 0, 1'b0, 0);
      run_frame(8'hC3, 8'h5A, 8'h25, 8'hDB, 0, 1'b0, 0);
      run_frame(8'hC3, 8'h5A, 8'h26, 8'h99, 0, 1'b0, 0);
      run_frame(8'hC3, 8'h5A, 8'h27, 8'h24, 0, 1'b0, 0);
      run_frame(8'hF0, 8'h01, 8'h02, 8'h78, 0, 1'b0, 0);
      run_frame(8'h01, 8'h01, 8'h55, 8'h00, 1, 1'b0, 0);
      run_frame(8'h11, 8'h22, 8'h20, 8'h33, 0, 1'b1, 0);
      run_frame(8'h0F, 8'h0F, 8'h24, 8'h0F, 0, 1'b0, 0);

      // Reset in the middle of a frame, with a stray tx_done in WAIT_OP.
      tick_byte(8'h01);
      tick_byte(8'h02);
      tx_done_tick = 1'b1;
      @(posedge clk);
      #1;
      tx_done_tick = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset_mid_busy", busy, 1'b0);
      check("reset_mid_tx_start", tx_start, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      run_frame(8'h02, 8'h01, 8'h22, 8'h01, 0, 1'b0, 0);

`ifdef UART_IF_TIMEOUT_EN
      tick_byte(8'h11);
      repeat (100) @(posedge clk);
      #1;
      exp_timeouts = 1;
      check("timeout_pulse", timeout_seen, exp_timeouts);
      check("timeout_idle", busy, 1'b0);
      run_frame(8'h11, 8'h22, 8'h20, 8'h33, 0, 1'b0, 0);
      run_frame(8'h40, 8'h04, 8'h02, 8'h04, 0, 1'b0, 99);
`endif

      repeat (5) @(posedge clk);
      #1;
      check("timeouts_total", timeout_seen, exp_timeouts);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
